if_stage_fq: RTL

Parametrised instruction-fetch stage. It is the successor of the single-entry BRAM fetch stage. It issues one fetch per cycle to a synchronous instruction memory with fixed read latency MEM_LAT, and buffers returned words in a FETCH_DEPTH-entry fetch queue. It presents {pc, instr} to decode with a valid/ready handshake. Branch/jump redirect and pipeline flush kill all queued and in-flight fetches.

---
 rtl/if_stage_fq_if.sv | 30 +++
 rtl/if_stage_fq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/if_stage_fq_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect/flush
// controls and the decode-side valid/ready handshake.
interface if_stage_fq_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FETCH_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FETCH_DEPTH) + 1;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            flush_i;
    logic            ready_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] instr_o;
    logic            valid_o;
    logic [CW-1:0]   fq_count_o;

    modport master (
        output imem_req_o, imem_addr_o, pc_o, instr_o, valid_o, fq_count_o,
        input  imem_rdata_i, redirect_i, redirect_pc_i, flush_i, ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, pc_o, instr_o, valid_o, fq_count_o,
        output imem_rdata_i, redirect_i, redirect_pc_i, flush_i, ready_i
    );
endinterface

// File: rtl/if_stage_fq.sv
// Instruction-fetch stage: credit-limited issue to a fixed-latency memory,
// in-flight tag pipe and a show-ahead fetch queue toward decode.
module if_stage_fq #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned     MEM_LAT     = 1,
    parameter int unsigned     FETCH_DEPTH = 4
) (
    input logic           clk_i,
    input logic           rst_ni,
    if_stage_fq_if.master bus
);
    localparam int unsigned     PW       = $clog2(FETCH_DEPTH);
    localparam int unsigned     CW       = PW + 1;
    localparam logic [CW:0]     DEPTH_L  = (CW + 1)'(FETCH_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] q_pc_r    [FETCH_DEPTH];
    logic [XLEN-1:0] q_instr_r [FETCH_DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [MEM_LAT-1:0] sr_vld_r;
    logic [XLEN-1:0] sr_pc_r   [MEM_LAT];

    logic [CW-1:0]   inflight_s;
    logic [CW:0]     credit_s;
    logic            valid_s;
    logic            pop_s;
    logic            push_s;
    logic            req_s;
    logic            kill_s;
    logic [XLEN-1:0] replay_pc_s;

    // Number of fetches issued but not yet returned
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight_s = inflight_s + CW'(sr_vld_r[i]);
        end
    end

    // Handshake and issue decision; a pop this cycle earns no credit
    always_comb begin
        valid_s  = (count_r != '0);
        pop_s    = valid_s && bus.ready_i;
        push_s   = sr_vld_r[MEM_LAT-1];
        kill_s   = bus.redirect_i || bus.flush_i;
        credit_s = {1'b0, count_r} + {1'b0, inflight_s};
        req_s    = rst_ni && (credit_s < DEPTH_L) && !kill_s;
    end

    // Flush replay point: oldest instruction decode has not consumed
    always_comb begin
        replay_pc_s = fetch_pc_r;
        for (int i = 0; i < MEM_LAT; i++) begin
            if (sr_vld_r[i]) begin
                replay_pc_s = sr_pc_r[i];
            end else begin
                replay_pc_s = replay_pc_s;
            end
        end
        if (valid_s && !pop_s) begin
            replay_pc_s = q_pc_r[rd_ptr_r];
        end else if (pop_s && (count_r > CNT_ONE)) begin
            replay_pc_s = q_pc_r[rd_ptr_r + PTR_ONE];
        end else begin
            replay_pc_s = replay_pc_s;
        end
    end

    // Output drive; head fields read as zero while the queue is empty
    always_comb begin
        bus.imem_req_o  = req_s;
        bus.imem_addr_o = fetch_pc_r;
        bus.valid_o     = valid_s;
        bus.fq_count_o  = count_r;
        if (valid_s) begin
            bus.pc_o    = q_pc_r[rd_ptr_r];
            bus.instr_o = q_instr_r[rd_ptr_r];
        end else begin
            bus.pc_o    = '0;
            bus.instr_o = '0;
        end
    end

    // Fetch PC, in-flight pipe and queue state
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_r <= RESET_PC;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            sr_vld_r   <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                sr_pc_r[i] <= '0;
            end
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                q_pc_r[i]    <= '0;
                q_instr_r[i] <= '0;
            end
        end else begin
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                sr_vld_r[i] <= sr_vld_r[i-1];
                sr_pc_r[i]  <= sr_pc_r[i-1];
            end
            sr_pc_r[0] <= fetch_pc_r;
            if (kill_s) begin
                // Returning response on this edge is dropped with the rest
                sr_vld_r <= '0;
                rd_ptr_r <= '0;
                wr_ptr_r <= '0;
                count_r  <= '0;
                if (bus.redirect_i) begin
                    fetch_pc_r <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
                end else begin
                    fetch_pc_r <= replay_pc_s;
                end
            end else begin
                sr_vld_r[0] <= req_s;
                if (req_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (push_s) begin
                    q_pc_r[wr_ptr_r]    <= sr_pc_r[MEM_LAT-1];
                    q_instr_r[wr_ptr_r] <= bus.imem_rdata_i;
                    wr_ptr_r            <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end
endmodule
